// File: rtl/shift_norm_pkg.sv
// Shared definitions for the shift normalizer.
//   - state_e      : FSM states (IDLE, RUN, DONE)
//   - STAGE_WIDTHS : shift width tested at each stage, largest first
//   - DATA_W / SHAMT_W / STAGE_IDX_W : fixed datapath, count and stage-index widths
package shift_norm_pkg;

  localparam int DATA_W      = 32;
  localparam int SHAMT_W     = 5;
  localparam int STAGE_IDX_W = 3;
  localparam int NUM_STAGES  = 5;

  // Binary decomposition of a 0..31 shift: one stage per shamt bit, MSB first.
  localparam int STAGE_WIDTHS [NUM_STAGES] = '{16, 8, 4, 2, 1};

  localparam logic [STAGE_IDX_W-1:0] LAST_STAGE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shift_normalizer_norm_step.sv
// norm_step: combinational single normalization stage.
//   value       in  32  current work value
//   stage_sel   in  3   stage index (0 -> width 16 ... 4 -> width 1)
//   signed_mode in  1   0 = leading-zero test, 1 = redundant-sign test
//   shifted     out 32  value shifted left by the stage width (zero-filled)
//   take        out 1   the stage's leading bits are redundant and may be shifted out
module norm_step
  import shift_norm_pkg::*;
(
  input  logic [DATA_W-1:0]      value,
  input  logic [STAGE_IDX_W-1:0] stage_sel,
  input  logic                   signed_mode,
  output logic [DATA_W-1:0]      shifted,
  output logic                   take
);

  logic [NUM_STAGES-1:0] take_w;
  logic [DATA_W-1:0]     shifted_w [NUM_STAGES];

  // Every width is evaluated in parallel; stage_sel just picks one.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    localparam int W = STAGE_WIDTHS[gi];
    logic [W-1:0] head_u;
    logic [W:0]   head_s;

    assign head_u = value[DATA_W-1 -: W];
    // Signed mode keeps one extra bit so the surviving MSB still carries the sign.
    assign head_s = value[DATA_W-1 -: W+1];

    assign take_w[gi]    = signed_mode ? ((head_s == '0) || (head_s == '1))
                                       : (head_u == '0);
    assign shifted_w[gi] = value << W;
  end

  always_comb begin
    take    = 1'b0;
    shifted = value;
    if (stage_sel <= LAST_STAGE) begin
      take    = take_w[stage_sel];
      shifted = shifted_w[stage_sel];
    end
  end

endmodule

// File: rtl/shift_normalizer.sv
// shift_normalizer: multi-cycle normalizer, one shift stage (16/8/4/2/1) per clock.
//   clk, rst     in   clock, synchronous active-high reset
//   start        in   request; accepted only in IDLE or DONE
//   in_data      in   32-bit operand, sampled with start
//   signed_mode  in   0 = count leading zeros, 1 = count redundant sign bits
//   busy         out  operation in progress
//   done         out  one-cycle pulse, results valid
//   out_data     out  normalized value (work register)
//   shamt        out  total left shift applied
//   zero         out  operand had no normalizing bit
module shift_normalizer
  import shift_norm_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  out_data,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero
);

  state_e                   state_q, state_d;
  logic [STAGE_IDX_W-1:0]   stage_q, stage_d;
  logic [DATA_W-1:0]        work_q, work_d;
  logic [SHAMT_W-1:0]       shamt_q, shamt_d;
  logic                     mode_q, mode_d;
  logic                     zero_q, zero_d;
  logic                     zero_pend_q, zero_pend_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [DATA_W-1:0]        step_value;
  logic                     step_take;

  norm_step u_step (
    .value       (work_q),
    .stage_sel   (stage_q),
    .signed_mode (mode_q),
    .shifted     (step_value),
    .take        (step_take)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    work_d      = work_q;
    shamt_d     = shamt_q;
    mode_d      = mode_q;
    zero_d      = zero_q;
    zero_pend_d = zero_pend_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          work_d      = in_data;
          mode_d      = signed_mode;
          shamt_d     = '0;
          zero_d      = 1'b0;
          // Decided from the raw operand; only published when the run completes.
          zero_pend_d = (in_data == '0) || (signed_mode && (in_data == '1));
          stage_d     = '0;
          state_d     = ST_RUN;
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (step_take) begin
          work_d  = step_value;
          // Stage 0 (width 16) owns shamt[4], stage 4 (width 1) owns shamt[0].
          shamt_d = shamt_q | (5'b10000 >> stage_q);
        end
        stage_d = stage_q + 3'd1;
        if (stage_q == LAST_STAGE) begin
          state_d = ST_DONE;
          zero_d  = zero_pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      work_q      <= '0;
      shamt_q     <= '0;
      mode_q      <= 1'b0;
      zero_q      <= 1'b0;
      zero_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      work_q      <= work_d;
      shamt_q     <= shamt_d;
      mode_q      <= mode_d;
      zero_q      <= zero_d;
      zero_pend_q <= zero_pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_data = work_q;
  assign shamt    = shamt_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_shift_normalizer.sv
// Directed testbench for shift_normalizer: table of hand-computed operands,
// handshake corner cases and mid-operation reset.
module tb_shift_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] in_data;
  logic        signed_mode;
  logic        busy;
  logic        done;
  logic [31:0] out_data;
  logic [4:0]  shamt;
  logic        zero;

  int vectors     = 0;
  int miscompares = 0;
  int overlap_cnt = 0;

  typedef struct packed {
    logic [31:0] din;
    logic        mode;
    logic [31:0] dout;
    logic [4:0]  sh;
    logic        z;
  } vec_t;

  vec_t vecs [9];

  shift_normalizer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .out_data    (out_data),
    .shamt       (shamt),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (busy && done) overlap_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (E0).
  task automatic start_op(input logic [31:0] din, input logic mode);
    start       = 1'b1;
    in_data     = din;
    signed_mode = mode;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    in_data     = ~din;   // later changes must not matter
    signed_mode = ~mode;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Returns the number of rising edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    int cnt;

    vecs[0] = '{32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0};
    vecs[1] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0};
    vecs[2] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0};
    vecs[3] = '{32'hFFFF_8000, 1'b1, 32'h8000_0000, 5'd16, 1'b0};
    vecs[4] = '{32'h0000_4000, 1'b1, 32'h4000_0000, 5'd16, 1'b0};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1};
    vecs[7] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 5'd0,  1'b0};

    rst = 1'b1; start = 1'b0; in_data = '0; signed_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_out",   out_data, 32'd0);
    chk("rst_shamt", {27'd0, shamt}, 32'd0);
    chk("rst_zero",  {31'd0, zero}, 32'd0);

    // Directed operand table.
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].din, vecs[i].mode);
      wait_done(edges);
      $display("vec %0d: in=%h mode=%0d -> out=%h shamt=%0d zero=%0d", i,
               vecs[i].din, vecs[i].mode, out_data, shamt, zero);
      chk($sformatf("v%0d_latency", i), edges + 1, 32'd6);
      chk($sformatf("v%0d_out", i),   out_data, vecs[i].dout);
      chk($sformatf("v%0d_shamt", i), {27'd0, shamt}, {27'd0, vecs[i].sh});
      chk($sformatf("v%0d_zero", i),  {31'd0, zero}, {31'd0, vecs[i].z});
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_out_held", i), out_data, vecs[i].dout);
    end

    // start pulses during RUN are ignored.
    start_op(32'h00F0_0000, 1'b0);           // after E0
    @(posedge clk); @(negedge clk);          // after E1
    start = 1'b1; in_data = 32'h0000_0001;
    @(posedge clk); @(negedge clk);          // E2 sampled start
    start = 1'b0;
    @(posedge clk); @(negedge clk);          // after E3
    start = 1'b1;
    @(posedge clk); @(negedge clk);          // E4 sampled start
    start = 1'b0;
    @(posedge clk); @(negedge clk);          // after E5
    $display("ignore: done=%0d out=%h shamt=%0d", done, out_data, shamt);
    chk("ign_done",  {31'd0, done}, 32'd1);
    chk("ign_out",   out_data, 32'hF000_0000);
    chk("ign_shamt", {27'd0, shamt}, 32'd8);
    count_dones(10, cnt);
    chk("ign_extra_dones", cnt, 32'd0);

    // start held high: back-to-back operations.
    start = 1'b1; in_data = 32'h0000_4000; signed_mode = 1'b1;
    @(posedge clk); @(negedge clk);
    in_data = 32'h0000_0001; signed_mode = 1'b0;
    wait_done(edges);
    $display("b2b first: out=%h shamt=%0d", out_data, shamt);
    chk("b2b1_latency", edges + 1, 32'd6);
    chk("b2b1_out",   out_data, 32'h4000_0000);
    chk("b2b1_shamt", {27'd0, shamt}, 32'd16);
    wait_done(edges);
    start = 1'b0;
    $display("b2b second: out=%h shamt=%0d", out_data, shamt);
    chk("b2b_period", edges, 32'd6);
    chk("b2b2_out",   out_data, 32'h8000_0000);
    chk("b2b2_shamt", {27'd0, shamt}, 32'd31);
    chk("b2b2_zero",  {31'd0, zero}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
    chk("b2b_idle_done", {31'd0, done}, 32'd0);

    // Reset sampled at E3 of an operation.
    start_op(32'h00F0_0000, 1'b0);           // after E0
    @(posedge clk); @(negedge clk);          // after E1
    @(posedge clk); @(negedge clk);          // after E2
    rst = 1'b1;
    @(posedge clk); @(negedge clk);          // E3 sampled rst
    $display("midrst: busy=%0d done=%0d out=%h shamt=%0d", busy, done, out_data, shamt);
    chk("midrst_busy",  {31'd0, busy}, 32'd0);
    chk("midrst_done",  {31'd0, done}, 32'd0);
    chk("midrst_out",   out_data, 32'd0);
    chk("midrst_shamt", {27'd0, shamt}, 32'd0);
    rst = 1'b0;
    count_dones(12, cnt);
    chk("midrst_no_done", cnt, 32'd0);

    // Simultaneous rst and start: start is not accepted.
    rst = 1'b1; start = 1'b1; in_data = 32'h0000_0001; signed_mode = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    count_dones(10, cnt);
    chk("rst_start_no_done", cnt, 32'd0);

    chk("busy_done_overlap", overlap_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_normalizer.md
# shift_normalizer

Multi-cycle normalizer for the ALU datapath. It left-shifts a 32-bit operand until the operand is normalized and reports the shift amount that was applied. This is the inverse of the barrel shifter: given a value, it recovers the left-shift count that produces a set MSB (unsigned mode) or a non-redundant sign bit (signed mode). It uses the same 16/8/4/2/1 stage decomposition, but runs one stage per clock behind a start/done handshake, and feeds count-leading-zeros and float-normalize paths.

## Interface
- No parameters; the datapath width is fixed at 32 and the count width at 5.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE or DONE.
- in_data  in  32  operand; sampled on the edge that accepts start.
- signed_mode  in  1  0 = count leading zeros; 1 = count redundant sign bits. Sampled with in_data.
- busy  out  1  high while an operation is in progress (states RUN).
- done  out  1  one-cycle pulse when results are valid.
- out_data  out  32  normalized value; held until the next accepted start.
- shamt  out  5  total left shift applied; held with out_data.
- zero  out  1  operand had no normalizing bit (all 0s, or all 1s in signed mode); held with out_data.

## Operation
- FSM states are IDLE, RUN, DONE. A 3-bit stage index selects widths 16, 8, 4, 2, 1 in that order.
- IDLE/DONE with start=1:
  - latch in_data into the work register and signed_mode into the mode register;
  - clear shamt and zero;
  - stage := 0;
  - go to RUN.
- RUN: for each stage of width w, test the work register:
  - unsigned: bits [31:32-w] are all 0;
  - signed: bits [31:31-w] (w+1 bits) are all equal.
- If the test passes:
  - the work register shifts left by w, zero-filled;
  - the shamt bit for w (bit 4 for 16 … bit 0 for 1) is set.
- If the test fails, the work register and shamt are unchanged.
- After the width-1 stage, the FSM goes to DONE.
- DONE:
  - done=1 for exactly this one cycle;
  - zero := 1 if the original operand was all 0s, or all 1s in signed mode. The flag is computed at latch time and registered.
  - With no start, the next state is IDLE. A start in DONE is accepted exactly as in IDLE (back-to-back operation).
- Degenerate operands always apply a shift of 31:
  - all-zero in unsigned or signed mode gives out_data=0 and shamt=31;
  - 0xFFFFFFFF in signed mode gives out_data=0x80000000 and shamt=31.
- start in RUN is ignored, with no queuing. in_data and signed_mode changes in RUN have no effect.
- out_data is the work register. It updates during RUN and is only guaranteed valid when done=1 and afterwards, until the next accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, out_data 0, shamt 0, zero 0.
- Latency:
  - start is accepted at edge E0;
  - stages execute at E1–E5;
  - done is high in the cycle after E5.
  - Total: 6 cycles from the start-sampling edge to the done-sampling edge.
- busy is high from after E0 through E5. busy and done are never high together.
- Throughput: one operation per 6 cycles, achieved by holding start high or pulsing it in DONE.
- rst takes priority over everything at any edge. Mid-operation reset goes to IDLE, clears all outputs, and produces no done pulse.
- A simultaneous rst and start gives reset; start is not accepted.

## Structure
- Package `shift_norm_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - the stage-width constants {16, 8, 4, 2, 1};
  - DATA_W=32 and SHAMT_W=5.
- Sub-module `norm_step` is combinational:
  - inputs: value, width select, and mode;
  - outputs: shifted value and a take flag.
- The top-level block holds the FSM, the work register, the shamt accumulation and the zero flag.

## Test plan
- Unsigned, in_data=0x00F00000 -> done after 6 cycles, out_data=0xF0000000, shamt=8, zero=0.
- Unsigned, 0x00000001 -> out_data=0x80000000, shamt=31. Also 0x80000000 -> unchanged, shamt=0.
- Signed, 0xFFFF8000 -> out_data=0x80000000, shamt=16. Signed, 0x00004000 -> out_data=0x40000000, shamt=16.
- Degenerate: unsigned 0 -> out_data=0, shamt=31, zero=1. Signed 0xFFFFFFFF -> out_data=0x80000000, shamt=31, zero=1.
- Handshake:
  - start pulsed twice during RUN -> ignored, single done;
  - start held high -> a done pulse every 6 cycles with correct back-to-back results.
- Reset: assert rst at E3 of an operation -> the next cycle shows busy=0, out_data=0 and shamt=0, and no done ever fires for that operation.
